mem_stage: RTL and testbench

- Pipeline MEM stage of the 16-bit core; consumer of the EX/MEM register fields and producer of `stall_mem_ready`.
- Performs loads and stores to data memory over a req/ack handshake.
- Stalls EX and earlier stages until the access completes.
- Registers the MEM/WB fields and drives the MEM/WB forwarding value `frwd_res_wb`.

---
 rtl/core_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage_access_fsm.sv | 88 ++++++++
 rtl/mem_stage.sv | 91 +++++++++
 tb/tb_mem_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core pipeline: MEM access FSM states,
// the load opcode, forwarding-select codes and the default memory timeout.
// No logic; imported by the MEM stage and its sub-module.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    localparam logic [3:0] OP_LOAD = 4'b1001;

    // Forwarding mux selects used by the EX stage operand muxes
    localparam logic [1:0] FORWARD_EX_RES  = 2'b10;
    localparam logic [1:0] FORWARD_MEM_RES = 2'b11;
    localparam logic [1:0] FORWARD_WB_RES  = 2'b01;

    // Default cycles to wait for mem_ack when the timeout build is enabled
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
// master: MEM stage (drives req/we/addr/wdata); slave: memory (drives rdata/ack).
// mem_ack is a one-cycle completion pulse; mem_rdata is valid with it.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_access_fsm.sv
// Data-memory access FSM: issues one request per memory op, holds it until ack.
// Ports: clk/rst, i_mop/i_addr/i_wdata/i_we request, mem bus (master),
//        o_state, o_rbuf read buffer, o_err (only with MEM_TIMEOUT_EN).
// Latency: request registered one cycle after issue; DONE follows the ack cycle.
module mem_access_fsm
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_mop,
    input  logic [15:0]        i_addr,
    input  logic [15:0]        i_wdata,
    input  logic               i_we,
    mem_stage_if.master        mem,
    output mem_state_t         o_state,
    output logic [15:0]        o_rbuf
`ifdef MEM_TIMEOUT_EN
   ,output logic               o_err
`endif
);

    mem_state_t  r_state;
    logic [15:0] r_rbuf;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign o_err = r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 16'h0000;
            r_rbuf        <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
            r_cnt         <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mop) begin
                        mem.mem_addr  <= i_addr;
                        mem.mem_wdata <= i_wdata;
                        mem.mem_we    <= i_we;
                        mem.mem_req   <= 1'b1;
                        r_state       <= REQ;
`ifdef MEM_TIMEOUT_EN
                        r_cnt         <= '0;
`endif
                    end
                end
                REQ: begin
                    // Ack takes priority over an expiring timeout
                    if (mem.mem_ack) begin
                        r_rbuf      <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        r_state     <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_rbuf      <= 16'hFFFF;
                        r_err       <= 1'b1;
                        mem.mem_req <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_rbuf  = r_rbuf;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory loads/stores plus the MEM/WB register.
// Ports: clk/rst; EX/MEM fields in (alu_res, ex_*, opcode_ex_mem); mem bus
//        (master); stall_mem_ready; MEM/WB fields out; frwd_res_wb; mem_err
//        only when MEM_TIMEOUT_EN is defined.
// Latency: non-memory ops 1 cycle; memory ops stall (ack latency + 1) cycles.
module mem_stage
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_res,
    input  logic [15:0] ex_store_data,
    input  logic [2:0]  ex_op_dest,
    input  logic        ex_mem_write_en,
    input  logic        ex_wb_mux,
    input  logic        ex_wb_en,
    input  logic [3:0]  opcode_ex_mem,
    output logic        stall_mem_ready,
    mem_stage_if.master mem_bus,
    output logic [15:0] wb_res,
    output logic [2:0]  wb_op_dest,
    output logic        wb_wb_en,
    output logic [3:0]  opcode_mem_wb,
    output logic [15:0] frwd_res_wb
`ifdef MEM_TIMEOUT_EN
   ,output logic        mem_err
`endif
);

    logic        w_mop;
    logic        w_stall;
    mem_state_t  w_state;
    logic [15:0] w_rbuf;

    logic [15:0] r_wb_res;
    logic [2:0]  r_wb_op_dest;
    logic        r_wb_wb_en;
    logic [3:0]  r_opcode_mem_wb;

    assign w_mop = ex_mem_write_en | (opcode_ex_mem == OP_LOAD);

    // The instruction stays in EX/MEM until the DONE cycle, when it retires.
    // Only state and EX/MEM fields feed this; mem_ack has no combinational path.
    assign w_stall = w_mop & (w_state != DONE);

    mem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .i_mop   (w_mop),
        .i_addr  (alu_res),
        .i_wdata (ex_store_data),
        .i_we    (ex_mem_write_en),
        .mem     (mem_bus),
        .o_state (w_state),
        .o_rbuf  (w_rbuf)
`ifdef MEM_TIMEOUT_EN
       ,.o_err   (mem_err)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_res        <= 16'h0000;
            r_wb_op_dest    <= 3'd0;
            r_wb_wb_en      <= 1'b0;
            r_opcode_mem_wb <= 4'h0;
        end else if (w_stall) begin
            // Bubble: kill write enable and opcode, keep data/dest as-is
            r_wb_wb_en      <= 1'b0;
            r_opcode_mem_wb <= 4'h0;
        end else begin
            r_wb_res        <= ex_wb_mux ? w_rbuf : alu_res;
            r_wb_op_dest    <= ex_op_dest;
            r_wb_wb_en      <= ex_wb_en;
            r_opcode_mem_wb <= opcode_ex_mem;
        end
    end

    assign stall_mem_ready = w_stall;
    assign wb_res          = r_wb_res;
    assign frwd_res_wb     = r_wb_res;
    assign wb_op_dest      = r_wb_op_dest;
    assign wb_wb_en        = r_wb_wb_en;
    assign opcode_mem_wb   = r_opcode_mem_wb;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed EX/MEM vectors, a memory responder with
// configurable ack latency, and a retire monitor popping an expected queue.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_res;
    logic [15:0] ex_store_data;
    logic [2:0]  ex_op_dest;
    logic        ex_mem_write_en;
    logic        ex_wb_mux;
    logic        ex_wb_en;
    logic [3:0]  opcode_ex_mem;
    logic        stall_mem_ready;
    logic [15:0] wb_res;
    logic [2:0]  wb_op_dest;
    logic        wb_wb_en;
    logic [3:0]  opcode_mem_wb;
    logic [15:0] frwd_res_wb;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    mem_stage_if mem_bus ();

    mem_stage #(
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .alu_res         (alu_res),
        .ex_store_data   (ex_store_data),
        .ex_op_dest      (ex_op_dest),
        .ex_mem_write_en (ex_mem_write_en),
        .ex_wb_mux       (ex_wb_mux),
        .ex_wb_en        (ex_wb_en),
        .opcode_ex_mem   (opcode_ex_mem),
        .stall_mem_ready (stall_mem_ready),
        .mem_bus         (mem_bus),
        .wb_res          (wb_res),
        .wb_op_dest      (wb_op_dest),
        .wb_wb_en        (wb_wb_en),
        .opcode_mem_wb   (opcode_mem_wb),
        .frwd_res_wb     (frwd_res_wb)
`ifdef MEM_TIMEOUT_EN
       ,.mem_err         (mem_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  dest;
        logic        en;
        logic [3:0]  opc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // memory responder controls and expected request fields
    int          resp_lat  = 1;
    logic [15:0] resp_data = 16'h0000;
    logic        spur_ack  = 1'b0;
    int          req_seen  = 0;
    logic [15:0] exp_addr  = 16'h0000;
    logic [15:0] exp_wdata = 16'h0000;
    logic        exp_we    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Memory model: ack in the resp_lat-th cycle of each request
    initial begin
        int k;
        k = 0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req === 1'b1) begin
                k++;
                req_seen++;
                chk("req_addr",  {16'h0, mem_bus.mem_addr},  {16'h0, exp_addr});
                chk("req_we",    {31'h0, mem_bus.mem_we},    {31'h0, exp_we});
                chk("req_wdata", {16'h0, mem_bus.mem_wdata}, {16'h0, exp_wdata});
            end else begin
                k = 0;
            end
            if (spur_ack) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = 16'hDEAD;
            end else if (mem_bus.mem_req === 1'b1 && k == resp_lat) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = resp_data;
            end else begin
                mem_bus.mem_ack   = 1'b0;
                mem_bus.mem_rdata = 16'h0000;
            end
        end
    end

    // Retire monitor: every non-bubble MEM/WB entry must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && opcode_mem_wb !== 4'h0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", {28'h0, opcode_mem_wb}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_res",        {16'h0, wb_res},        {16'h0, e.res});
                    chk("frwd_res_wb",   {16'h0, frwd_res_wb},   {16'h0, e.res});
                    chk("wb_op_dest",    {29'h0, wb_op_dest},    {29'h0, e.dest});
                    chk("wb_wb_en",      {31'h0, wb_wb_en},      {31'h0, e.en});
                    chk("opcode_mem_wb", {28'h0, opcode_mem_wb}, {28'h0, e.opc});
                end
            end
        end
    end

    task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] dest,
                         input logic we, input logic mux, input logic wben, input logic [3:0] opc);
        alu_res         = alu;
        ex_store_data   = sd;
        ex_op_dest      = dest;
        ex_mem_write_en = we;
        ex_wb_mux       = mux;
        ex_wb_en        = wben;
        opcode_ex_mem   = opc;
    endtask

    // Issue one instruction (called just after a posedge) and wait for it to retire
    task automatic do_op(input string name, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [2:0] dest, input logic we, input logic mux, input logic wben,
                         input logic [3:0] opc, input int lat, input logic [15:0] rdata,
                         input logic [15:0] exp_res, input int exp_req, input int exp_stall);
        int nst;
        exp_t e;
        resp_lat  = lat;
        resp_data = rdata;
        exp_addr  = alu;
        exp_wdata = sd;
        exp_we    = we;
        req_seen  = 0;
        e.res = exp_res; e.dest = dest; e.en = wben; e.opc = opc;
        exp_q.push_back(e);
        drive(alu, sd, dest, we, mux, wben, opc);
        nst = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall_mem_ready !== 1'b1) break;
            nst++;
            if (c > 0) chk({name, "_bubble_wb_en"}, {31'h0, wb_wb_en}, 32'h0);
        end
        chk({name, "_stall_cycles"}, nst, exp_stall);
        chk({name, "_req_cycles"}, req_seen, exp_req);
        @(posedge clk); #1;
    endtask

    task automatic nop(input int n);
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        #12;
        chk("rst_mem_req",   {31'h0, mem_bus.mem_req},   32'h0);
        chk("rst_mem_we",    {31'h0, mem_bus.mem_we},    32'h0);
        chk("rst_mem_addr",  {16'h0, mem_bus.mem_addr},  32'h0);
        chk("rst_mem_wdata", {16'h0, mem_bus.mem_wdata}, 32'h0);
        chk("rst_wb_res",    {16'h0, wb_res},            32'h0);
        chk("rst_wb_en",     {31'h0, wb_wb_en},          32'h0);
        chk("rst_opcode",    {28'h0, opcode_mem_wb},     32'h0);
        chk("rst_stall",     {31'h0, stall_mem_ready},   32'h0);
`ifdef MEM_TIMEOUT_EN
        chk("rst_mem_err",   {31'h0, mem_err},           32'h0);
`endif
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // ALU op: zero stall, one-cycle latency
        do_op("alu",   16'h1234, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 4'h1, 1, 16'h0, 16'h1234, 0, 0);
        // Load, ack in first REQ cycle
        do_op("load",  16'h0040, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 4'h9, 1, 16'hBEEF, 16'hBEEF, 1, 2);
        nop(1);
        // Store, ack after 3 cycles, no writeback
        do_op("store", 16'h0010, 16'hA5A5, 3'd2, 1'b1, 1'b0, 1'b0, 4'hA, 3, 16'h0000, 16'h0010, 3, 4);
        // Back-to-back loads
        do_op("ld_a",  16'h0100, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b1, 4'h9, 1, 16'h1111, 16'h1111, 1, 2);
        do_op("ld_b",  16'h0102, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b1, 4'h9, 1, 16'h2222, 16'h2222, 1, 2);
        // ALU op with write disabled
        do_op("alu_nw", 16'hCAFE, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0, 4'h3, 1, 16'h0, 16'hCAFE, 0, 0);
        nop(1);

        // Reset in the middle of a REQ phase
        resp_lat = 10; exp_addr = 16'h0300; exp_wdata = 16'h0000; exp_we = 1'b0;
        drive(16'h0300, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b1, 4'h9);
        repeat (3) @(negedge clk);
        chk("pre_rst_req", {31'h0, mem_bus.mem_req}, 32'h1);
        #1;
        rst = 1'b1;
        drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        #1;
        chk("arst_mem_req",  {31'h0, mem_bus.mem_req},   32'h0);
        chk("arst_stall",    {31'h0, stall_mem_ready},   32'h0);
        chk("arst_mem_addr", {16'h0, mem_bus.mem_addr},  32'h0);
        chk("arst_wb_res",   {16'h0, wb_res},            32'h0);
        chk("arst_wb_dest",  {29'h0, wb_op_dest},        32'h0);
        chk("arst_opcode",   {28'h0, opcode_mem_wb},     32'h0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        // Spurious ack in IDLE must not start anything or load the read buffer
        spur_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
        end
        spur_ack = 1'b0;
        @(posedge clk); #1;
        do_op("rbuf_clr", 16'h5555, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b1, 4'h1, 1, 16'h0, 16'h0000, 0, 0);
        // Load after reset, ack latency 2
        do_op("ld_post", 16'h0200, 16'h0000, 3'd2, 1'b0, 1'b1, 1'b1, 4'h9, 2, 16'h7777, 16'h7777, 2, 3);
        nop(1);

`ifdef MEM_TIMEOUT_EN
        // No ack: times out after 4 REQ cycles
        do_op("tmo", 16'h0400, 16'h0000, 3'd3, 1'b0, 1'b1, 1'b1, 4'h9, 100, 16'h0, 16'hFFFF, 4, 5);
        chk("tmo_mem_err", {31'h0, mem_err}, 32'h1);
        do_op("tmo_after", 16'h0042, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 4'h2, 1, 16'h0, 16'h0042, 0, 0);
        chk("tmo_err_sticky", {31'h0, mem_err}, 32'h1);
`endif

        nop(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
